// File: rtl/seq_pkg.sv
// Shared defaults and helpers for the match logger and its timestamp FIFO.
package seq_pkg;
  localparam int TS_W_DEF  = 16;
  localparam int CNT_W_DEF = 16;
  localparam int DEPTH_DEF = 8;

  // Occupancy needs one bit more than the pointers to represent "full".
  function automatic int fill_w(input int depth);
    return $clog2(depth) + 1;
  endfunction
endpackage

// File: rtl/seq_ts_fifo.sv
// First-word-fall-through FIFO; full/empty come from the occupancy count.
module seq_ts_fifo
  import seq_pkg::*;
#(
  parameter int W     = TS_W_DEF,
  parameter int DEPTH = DEPTH_DEF
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      clr,
  input  logic                      push,
  input  logic [W-1:0]              din,
  input  logic                      pop,
  output logic [W-1:0]              dout,
  output logic                      valid,
  output logic [fill_w(DEPTH)-1:0]  fill,
  output logic                      full
);
  localparam int PTR_W  = $clog2(DEPTH);
  localparam int FILL_W = fill_w(DEPTH);

  logic [W-1:0]     mem [DEPTH];
  logic [PTR_W-1:0] rptr;
  logic [PTR_W-1:0] wptr;
  logic             pop_ok;
  logic             push_ok;

  assign valid   = (fill != '0);
  assign full    = (fill == FILL_W'(DEPTH));
  assign pop_ok  = pop && valid && !clr;
  // A pop in the same cycle frees the slot the push needs; otherwise a full push drops.
  assign push_ok = push && !clr && (!full || pop_ok);
  assign dout    = valid ? mem[rptr] : '0;

  always_ff @(posedge clk) begin
    if (push_ok) mem[wptr] <= din;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rptr <= '0;
      wptr <= '0;
      fill <= '0;
    end else if (clr) begin
      rptr <= '0;
      wptr <= '0;
      fill <= '0;
    end else begin
      if (push_ok) wptr <= wptr + 1'b1;
      if (pop_ok)  rptr <= rptr + 1'b1;
      case ({push_ok, pop_ok})
        2'b10:   fill <= fill + 1'b1;
        2'b01:   fill <= fill - 1'b1;
        default: fill <= fill;
      endcase
    end
  end
endmodule

// File: rtl/seq_match_logger.sv
// Counts detector matches and queues a timestamp for each one for host readout.
module seq_match_logger
  import seq_pkg::*;
#(
  parameter int TS_W  = TS_W_DEF,
  parameter int CNT_W = CNT_W_DEF,
  parameter int DEPTH = DEPTH_DEF
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      en,
  input  logic                      clear,
  input  logic                      match_in,
  output logic [TS_W-1:0]           ts_data,
  output logic                      ts_valid,
  input  logic                      ts_ready,
  output logic [CNT_W-1:0]          match_count,
  output logic [fill_w(DEPTH)-1:0]  fill,
  output logic                      overflow
);
  logic [TS_W-1:0] ts;
  logic            capture;
  logic            pop_ok;
  logic            full;

  assign capture = match_in && en && !clear;
  assign pop_ok  = ts_valid && ts_ready;

  seq_ts_fifo #(
    .W     (TS_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .clr   (clear),
    .push  (capture),
    .din   (ts),
    .pop   (ts_ready),
    .dout  (ts_data),
    .valid (ts_valid),
    .fill  (fill),
    .full  (full)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ts          <= '0;
      match_count <= '0;
      overflow    <= 1'b0;
    end else if (clear) begin
      ts          <= '0;
      match_count <= '0;
      overflow    <= 1'b0;
    end else begin
      if (en) ts <= ts + 1'b1;
      if (capture && (match_count != '1)) match_count <= match_count + 1'b1;
      // Dropped matches still count; only the timestamp is lost.
      if (capture && full && !pop_ok) overflow <= 1'b1;
    end
  end
endmodule

// File: tb/tb_seq_match_logger.sv
// Drives a default-sized logger and a narrow one (TS_W=4, CNT_W=3, DEPTH=4) against a queue model.
module tb_seq_match_logger;
  logic clk = 1'b0;
  logic rst, en, clear, match_in, ts_ready;

  logic [15:0] ts_data0;
  logic        ts_valid0;
  logic [15:0] mc0;
  logic [3:0]  fill0;
  logic        ovf0;

  logic [3:0]  ts_data1;
  logic        ts_valid1;
  logic [2:0]  mc1;
  logic [2:0]  fill1;
  logic        ovf1;

  int compared   = 0;
  int mismatched = 0;

  int unsigned mts  [2];
  int unsigned mcnt [2];
  bit          movf [2];
  int unsigned q0[$];
  int unsigned q1[$];

  always #5 clk = ~clk;

  seq_match_logger u_dut0 (
    .clk(clk), .rst(rst), .en(en), .clear(clear), .match_in(match_in),
    .ts_data(ts_data0), .ts_valid(ts_valid0), .ts_ready(ts_ready),
    .match_count(mc0), .fill(fill0), .overflow(ovf0)
  );

  seq_match_logger #(.TS_W(4), .CNT_W(3), .DEPTH(4)) u_dut1 (
    .clk(clk), .rst(rst), .en(en), .clear(clear), .match_in(match_in),
    .ts_data(ts_data1), .ts_valid(ts_valid1), .ts_ready(ts_ready),
    .match_count(mc1), .fill(fill1), .overflow(ovf1)
  );

  function automatic int unsigned ts_mod(input int k);
    return (k == 0) ? 32'd65536 : 32'd16;
  endfunction
  function automatic int unsigned cnt_max(input int k);
    return (k == 0) ? 32'd65535 : 32'd7;
  endfunction
  function automatic int unsigned depth(input int k);
    return (k == 0) ? 32'd8 : 32'd4;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset(input int k);
    mts[k]  = 0;
    mcnt[k] = 0;
    movf[k] = 1'b0;
    if (k == 0) q0.delete(); else q1.delete();
  endtask

  // Applies one clock edge of the logging rules using the inputs currently driven.
  task automatic model_edge(input int k);
    int unsigned sz;
    sz = (k == 0) ? q0.size() : q1.size();
    if (clear) begin
      model_reset(k);
    end else begin
      if (ts_ready && sz > 0) begin
        if (k == 0) void'(q0.pop_front()); else void'(q1.pop_front());
        sz--;
      end
      if (match_in && en) begin
        if (mcnt[k] < cnt_max(k)) mcnt[k]++;
        if (sz < depth(k)) begin
          if (k == 0) q0.push_back(mts[k]); else q1.push_back(mts[k]);
        end else begin
          movf[k] = 1'b1;
        end
      end
      if (en) mts[k] = (mts[k] + 1) % ts_mod(k);
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".valid0"}, 32'(ts_valid0), 32'(q0.size() != 0));
    chk({tag, ".data0"},  32'(ts_data0),  (q0.size() != 0) ? q0[0] : 32'd0);
    chk({tag, ".fill0"},  32'(fill0),     q0.size());
    chk({tag, ".count0"}, 32'(mc0),       mcnt[0]);
    chk({tag, ".ovf0"},   32'(ovf0),      32'(movf[0]));
    chk({tag, ".valid1"}, 32'(ts_valid1), 32'(q1.size() != 0));
    chk({tag, ".data1"},  32'(ts_data1),  (q1.size() != 0) ? q1[0] : 32'd0);
    chk({tag, ".fill1"},  32'(fill1),     q1.size());
    chk({tag, ".count1"}, 32'(mc1),       mcnt[1]);
    chk({tag, ".ovf1"},   32'(ovf1),      32'(movf[1]));
  endtask

  task automatic step(input string tag, input bit e, input bit m, input bit r, input bit c);
    en = e; match_in = m; ts_ready = r; clear = c;
    @(posedge clk);
    model_edge(0);
    model_edge(1);
    #1;
    check_all(tag);
  endtask

  initial begin
    int unsigned frozen;
    bit re, rm, rr, rc;

    rst = 1'b1; en = 1'b0; clear = 1'b0; match_in = 1'b0; ts_ready = 1'b0;
    model_reset(0);
    model_reset(1);
    repeat (2) @(posedge clk);
    #1;
    check_all("reset");
    rst = 1'b0;

    // Single capture at ts=5, then one pop.
    while (mts[0] != 5) step("idle", 1, 0, 0, 0);
    step("single", 1, 1, 0, 0);
    chk("single.data", 32'(ts_data0), 5);
    chk("single.count", 32'(mc0), 1);
    chk("single.fill", 32'(fill0), 1);
    step("single_pop", 1, 0, 1, 0);
    chk("single_pop.valid", 32'(ts_valid0), 0);

    // Clear with a coincident pulse.
    step("pre_clr", 1, 1, 0, 0);
    step("pre_clr", 1, 1, 0, 0);
    step("clr_pulse", 1, 1, 0, 1);
    chk("clr.count", 32'(mc0), 0);
    chk("clr.fill", 32'(fill0), 0);
    step("post_clr", 1, 1, 0, 0);
    chk("post_clr.data", 32'(ts_data0), 0);

    // Overflow: ten pulses at ts=10,12,..,28 with no reads.
    step("clr", 1, 0, 0, 1);
    while (mts[0] <= 28) step("ovf_fill", 1, (mts[0] >= 10) && (mts[0] % 2 == 0), 0, 0);
    chk("ovf.fill", 32'(fill0), 8);
    chk("ovf.flag", 32'(ovf0), 1);
    chk("ovf.count", 32'(mc0), 10);
    for (int i = 0; i < 8; i++) begin
      chk("ovf.drain", 32'(ts_data0), 32'(10 + 2 * i));
      step("ovf_drain", 1, 0, 1, 0);
    end
    chk("ovf.empty", 32'(ts_valid0), 0);

    // Full FIFO with a push and a pop in the same cycle.
    step("clr", 1, 0, 0, 1);
    for (int i = 0; i < 8; i++) step("full_fill", 1, 1, 0, 0);
    step("full_pushpop", 1, 1, 1, 0);
    chk("fullpop.fill", 32'(fill0), 8);
    chk("fullpop.ovf", 32'(ovf0), 0);
    for (int i = 0; i < 8; i++) begin
      chk("fullpop.drain", 32'(ts_data0), 32'(i + 1));
      step("fullpop_drain", 1, 0, 1, 0);
    end

    // Pulses with logging disabled are ignored and ts holds.
    frozen = mts[0];
    for (int i = 0; i < 4; i++) step("en_off", 0, 1, 0, 0);
    chk("en_off.fill", 32'(fill0), 0);
    step("en_on", 1, 1, 0, 0);
    chk("en_on.data", 32'(ts_data0), frozen);

    // Narrow instance: timestamp wrap 15 -> 0.
    step("clr", 1, 0, 0, 1);
    while (mts[1] != 15) step("wrap_run", 1, 0, 0, 0);
    step("wrap_a", 1, 1, 0, 0);
    step("wrap_b", 1, 1, 0, 0);
    chk("wrap.first", 32'(ts_data1), 15);
    step("wrap_pop", 1, 0, 1, 0);
    chk("wrap.second", 32'(ts_data1), 0);
    step("wrap_pop", 1, 0, 1, 0);

    // Narrow instance: count saturates at 7.
    step("clr", 1, 0, 0, 1);
    for (int i = 0; i < 9; i++) step("sat", 1, 1, 1, 0);
    chk("sat.count1", 32'(mc1), 7);
    chk("sat.count0", 32'(mc0), 9);

    // Asynchronous reset mid-run with three entries queued.
    step("clr", 1, 0, 0, 1);
    for (int i = 0; i < 3; i++) step("rst_fill", 1, 1, 0, 0);
    chk("rst.prefill", 32'(fill0), 3);
    #2;
    rst = 1'b1;
    #1;
    model_reset(0);
    model_reset(1);
    check_all("async_rst");
    chk("async_rst.fill", 32'(fill0), 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    step("rst_restart", 1, 1, 0, 0);
    chk("rst_restart.data", 32'(ts_data0), 0);

    // Randomized traffic.
    step("clr", 1, 0, 0, 1);
    for (int i = 0; i < 400; i++) begin
      re = ($urandom_range(0, 9) != 0);
      rm = ($urandom_range(0, 2) == 0);
      rr = ($urandom_range(0, 2) == 0);
      rc = ($urandom_range(0, 59) == 0);
      step("rand", re, rm, rr, rc);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
